// File: rtl/riscv_multicycle_pkg.sv
// Shared types for the multi-cycle sequencer: FSM states, trap causes and
// memory address-mux select values.
package riscv_multicycle_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        FETCH_REQ  = 4'd1,
        FETCH_WAIT = 4'd2,
        DECODE     = 4'd3,
        EXECUTE    = 4'd4,
        MEM_REQ    = 4'd5,
        MEM_WAIT   = 4'd6,
        WRITEBACK  = 4'd7,
        TRAP       = 4'd8
    } seq_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } trap_cause_e;

    localparam logic MEM_SEL_PC  = 1'b0;
    localparam logic MEM_SEL_ALU = 1'b1;

endpackage

// File: rtl/riscv_bus_timeout.sv
// Wait-cycle counter for the shared memory port; flags the waiting cycle on
// which TIMEOUT_CYCLES is reached. TIMEOUT_CYCLES = 0 never expires.
module riscv_bus_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired_c
);
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic        ENABLED = (TIMEOUT_CYCLES != 0);

    logic [CNT_W-1:0] r_cnt;

    // Counts completed wait cycles; saturates so a disabled timer cannot wrap into LAST.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired_c = ENABLED && i_en && (r_cnt == LAST);

endmodule

// File: rtl/riscv_multicycle_sequencer.sv
// Multi-cycle RISC-V sequencer: steps FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a
// single shared memory port and halts in a sticky trap on illegal opcode or bus timeout.
module riscv_multicycle_sequencer
    import riscv_multicycle_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned RETIRE_WIDTH   = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_branch,
    input  logic                    i_jump,
    input  logic                    i_mem_read,
    input  logic                    i_mem_write,
    input  logic                    i_reg_write,
    input  logic                    i_illegal,
    input  logic                    i_mem_ready,
    input  logic                    i_mem_rvalid,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic                    o_mem_sel,
    output logic                    o_ir_we,
    output logic                    o_pc_we,
    output logic                    o_rf_we,
    output logic                    o_busy,
    output logic                    o_trap,
    output logic [1:0]              o_trap_cause,
    output logic [RETIRE_WIDTH-1:0] o_retired
);
    seq_state_e              r_state;
    seq_state_e              w_next;
    trap_cause_e             r_cause;
    trap_cause_e             w_cause_next;
    logic [RETIRE_WIDTH-1:0] r_retired;
    logic                    w_tmo_clear;
    logic                    w_tmo_en;
    logic                    w_tmo_expired;
    logic                    w_unused;

    // Branches need no sequencing of their own: they share the no-writeback
    // fall-through path and the datapath picks the target.
    assign w_unused = i_branch;

    riscv_bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_bus_timeout (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (w_tmo_clear),
        .i_en        (w_tmo_en),
        .o_expired_c (w_tmo_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cause   <= CAUSE_NONE;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause_next;
            if (o_pc_we) begin
                r_retired <= r_retired + RETIRE_WIDTH'(1);
            end
        end
    end

    // Next-state and strobe decode; strobes are same-cycle functions of state/inputs.
    always_comb begin
        w_next       = r_state;
        w_cause_next = r_cause;
        w_tmo_clear  = 1'b0;
        w_tmo_en     = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_sel    = MEM_SEL_PC;
        o_ir_we      = 1'b0;
        o_pc_we      = 1'b0;
        o_rf_we      = 1'b0;
        o_busy       = 1'b1;
        o_trap       = 1'b0;
        unique case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = FETCH_REQ;
            end
            FETCH_REQ: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) begin
                    w_next      = FETCH_WAIT;
                    w_tmo_clear = 1'b1;
                end
            end
            FETCH_WAIT: begin
                w_tmo_en = 1'b1;
                if (i_mem_rvalid) begin
                    o_ir_we = 1'b1;
                    w_next  = DECODE;
                end else if (w_tmo_expired) begin
                    w_next       = TRAP;
                    w_cause_next = CAUSE_TIMEOUT;
                end
            end
            DECODE: begin
                if (i_illegal) begin
                    w_next       = TRAP;
                    w_cause_next = CAUSE_ILLEGAL;
                end else begin
                    w_next = EXECUTE;
                end
            end
            EXECUTE: begin
                if (i_mem_read || i_mem_write) begin
                    w_next = MEM_REQ;
                end else if (i_reg_write || i_jump) begin
                    w_next = WRITEBACK;
                end else begin
                    o_pc_we = 1'b1;
                    w_next  = FETCH_REQ;
                end
            end
            MEM_REQ: begin
                o_mem_req = 1'b1;
                o_mem_sel = MEM_SEL_ALU;
                o_mem_we  = i_mem_write;
                if (i_mem_ready) begin
                    w_next      = MEM_WAIT;
                    w_tmo_clear = 1'b1;
                end
            end
            MEM_WAIT: begin
                w_tmo_en = 1'b1;
                if (i_mem_rvalid) begin
                    if (i_mem_write) begin
                        o_pc_we = 1'b1;
                        w_next  = FETCH_REQ;
                    end else begin
                        w_next = WRITEBACK;
                    end
                end else if (w_tmo_expired) begin
                    w_next       = TRAP;
                    w_cause_next = CAUSE_TIMEOUT;
                end
            end
            WRITEBACK: begin
                o_rf_we = 1'b1;
                o_pc_we = 1'b1;
                w_next  = FETCH_REQ;
            end
            TRAP: begin
                o_busy = 1'b0;
                o_trap = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
                w_next = IDLE;
            end
        endcase
    end

    assign o_trap_cause = r_cause;
    assign o_retired    = r_retired;

endmodule
